voice_scheduler: RTL and testbench
==================================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4: number of time-multiplexed voices.
REQ-002 SHALL have parameter PHASE_BITS, default 24: phase accumulator width per voice.
REQ-003 SHALL have parameter ADDR_BITS, default 8: sine ROM address width.
REQ-004 SHALL have parameter DATA_BITS, default 12: sine ROM sample width, offset-binary.
REQ-005 SHALL have port clk  input  1: sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-007 SHALL have port sample_tick  input  1: one-cycle pulse requesting one mixed sample.
REQ-008 SHALL have port voice_en  input  NUM_VOICES: per-voice enable.
REQ-009 SHALL have port phase_inc  input  NUM_VOICES*PHASE_BITS: per-voice increment; voice v occupies bits [v*PHASE_BITS +: PHASE_BITS].
REQ-010 SHALL have port rom_addr  output  ADDR_BITS: address to the shared sine_rom.
REQ-011 SHALL have port rom_data  input  DATA_BITS: sine_rom output, valid one cycle after rom_addr.
REQ-012 SHALL have port mix_out  output  DATA_BITS+$clog2(NUM_VOICES): signed two's-complement voice sum.
REQ-013 SHALL have port mix_valid  output  1: one-cycle strobe; mix_out is new.
REQ-014 SHALL have port busy  output  1: high while a sample is being computed.
REQ-015 SHALL have port overrun  output  1: sticky flag; a tick arrived while busy.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-017 IDLE: on sample_tick, snapshot voice_en and phase_inc, clear accumulator, clear slot counter, go to FETCH.
REQ-018 FETCH: one slot per cycle, slot 0..NUM_VOICES-1; rom_addr = phase[slot][PHASE_BITS-1 -: ADDR_BITS], using the pre-increment phase; go to DRAIN after the last slot.
REQ-019 At each slot issue: if the snapshot enable is 1, phase[slot] <= phase[slot] + inc, wrapping modulo 2^PHASE_BITS; otherwise phase[slot] <= 0.
REQ-020 In the cycle after each issue, add rom_data with its MSB inverted (to signed) into the accumulator if that slot was enabled; add 0 otherwise.
REQ-021 DRAIN: accumulate the last slot, go to DONE.
REQ-022 DONE: register the accumulator into mix_out, pulse mix_valid for exactly one cycle, return to IDLE.
REQ-023 Latency: tick in cycle T gives mix_valid in cycle T+NUM_VOICES+2 (T+6 for 4 voices).
REQ-024 busy SHALL be high in FETCH and DRAIN, and low in IDLE and DONE.
REQ-025 A sample_tick in any state other than IDLE is ignored and sets overrun; overrun clears only on reset.
REQ-026 A tick in the DONE cycle also counts as overrun; a tick in the cycle after DONE is accepted.
REQ-027 mix_out SHALL hold its value between mix_valid pulses.
REQ-028 The accumulator SHALL not overflow; the full-scale range is NUM_VOICES*[-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
REQ-029 rom_addr SHALL hold its last value outside FETCH.

Reset
REQ-030 While rst_n=0 at a clock edge: state IDLE, all phases 0, accumulator 0, rom_addr 0, mix_out 0, mix_valid 0, busy 0, overrun 0.
REQ-031 Reset mid-computation SHALL abort the computation with no mix_valid pulse; the first tick after release starts a fresh computation.

Structure
REQ-032 NUM_VOICES, PHASE_BITS, ADDR_BITS, DATA_BITS defaults and the FSM state enum SHALL live in shared package synth_pkg.
REQ-033 The phase registers plus increment/clear logic SHALL be one sub-module, voice_phase_bank, indexed by slot.
REQ-034 The sine_rom instance SHALL stay outside this block and is connected at top level.

Verification (bench ROM model: rom[a]=a*16, registered read, 1 cycle)
REQ-035 Voice 0 only, inc=0x010000, 4 ticks spaced 10 cycles -> rom_addr 0,1,2,3; mix_out -2048,-2032,-2016,-2000.
REQ-036 All 4 voices enabled, inc=0, tick at T -> mix_valid only at T+6; mix_out -8192; busy high T+1..T+5.
REQ-037 Voice 1 only, inc=0x800000, 4 ticks -> rom_addr 0,128,0,128 (wrap); mix_out -2048,0,-2048,0.
REQ-038 Tick at T and at T+3 -> one mix_valid at T+6; overrun=1 and remains 1 through later ticks until rst_n=0.
REQ-039 Voice 0 enabled inc=0x010000 for 3 samples, then disabled for 1, then re-enabled -> next rom_addr for voice 0 is 0 (phase cleared).
REQ-040 rst_n=0 at T+3 after a tick -> no mix_valid; all outputs 0; the next tick yields rom_addr 0 for every slot.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared defaults and FSM encoding for the voice scheduler slice.
package synth_pkg;

   localparam int unsigned NUM_VOICES_DEF = 4;
   localparam int unsigned PHASE_BITS_DEF = 24;
   localparam int unsigned ADDR_BITS_DEF  = 8;
   localparam int unsigned DATA_BITS_DEF  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/voice_phase_bank.sv
// Per-voice phase accumulators: one slot updated per issue, one slot read for addressing.
module voice_phase_bank
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
   parameter int unsigned PHASE_BITS = PHASE_BITS_DEF,
   parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
   localparam int unsigned SLOT_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             issue,
   input  logic [SLOT_W-1:0]                slot,
   input  logic [NUM_VOICES-1:0]            en_vec,
   input  logic [NUM_VOICES*PHASE_BITS-1:0] inc_vec,
   input  logic [SLOT_W-1:0]                rd_slot,
   output logic [ADDR_BITS-1:0]             rd_addr_c
);

   logic [PHASE_BITS-1:0] phase [NUM_VOICES];

   // Advance an enabled voice modulo 2^PHASE_BITS; a disabled voice restarts from zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int v = 0; v < int'(NUM_VOICES); v++) begin
            phase[v] <= '0;
         end
      end else if (issue) begin
         if (en_vec[slot]) begin
            phase[slot] <= phase[slot] + inc_vec[32'(slot)*PHASE_BITS +: PHASE_BITS];
         end else begin
            phase[slot] <= '0;
         end
      end
   end

   // Sine ROM address is the top bits of the selected phase.
   assign rd_addr_c = phase[rd_slot][PHASE_BITS-1 -: ADDR_BITS];

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes NUM_VOICES sine voices through one shared ROM and sums them per sample tick.
module voice_scheduler
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
   parameter int unsigned PHASE_BITS = PHASE_BITS_DEF,
   parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          sample_tick,
   input  logic [NUM_VOICES-1:0]                         voice_en,
   input  logic [NUM_VOICES*PHASE_BITS-1:0]              phase_inc,
   output logic [ADDR_BITS-1:0]                          rom_addr,
   input  logic [DATA_BITS-1:0]                          rom_data,
   output logic signed [DATA_BITS+$clog2(NUM_VOICES)-1:0] mix_out,
   output logic                                          mix_valid,
   output logic                                          busy,
   output logic                                          overrun
);

   localparam int unsigned MIX_W  = DATA_BITS + $clog2(NUM_VOICES);
   localparam int unsigned SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

   sched_state_e                    state_q, state_d;
   logic [SLOT_W-1:0]               slot_q;
   logic [NUM_VOICES-1:0]           en_snap;
   logic [NUM_VOICES*PHASE_BITS-1:0] inc_snap;
   logic                            pend_q, pend_en_q;
   logic signed [MIX_W-1:0]         acc_q;

   logic                            start_c, issue_c, drain_c;
   logic [SLOT_W-1:0]               rd_slot_c;
   logic [ADDR_BITS-1:0]            bank_addr_c;
   logic signed [DATA_BITS-1:0]     sample_c;
   logic signed [MIX_W-1:0]         addend_c;

   voice_phase_bank #(
      .NUM_VOICES (NUM_VOICES),
      .PHASE_BITS (PHASE_BITS),
      .ADDR_BITS  (ADDR_BITS)
   ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .issue     (issue_c),
      .slot      (slot_q),
      .en_vec    (en_snap),
      .inc_vec   (inc_snap),
      .rd_slot   (rd_slot_c),
      .rd_addr_c (bank_addr_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sample_tick) state_d = FETCH;
         FETCH:   if (slot_q == LAST_SLOT) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control decode; the read slot looks one ahead so rom_addr is registered in time.
   always_comb begin
      start_c   = 1'b0;
      issue_c   = 1'b0;
      drain_c   = 1'b0;
      rd_slot_c = '0;
      case (state_q)
         IDLE:  start_c = sample_tick;
         FETCH: begin
            issue_c = 1'b1;
            if (slot_q != LAST_SLOT) rd_slot_c = slot_q + 1'b1;
         end
         DRAIN: drain_c = 1'b1;
         default: ;
      endcase
   end

   // ROM sample from the previous issue, converted from offset-binary to signed; zero when masked.
   always_comb begin
      sample_c = $signed({~rom_data[DATA_BITS-1], rom_data[DATA_BITS-2:0]});
      addend_c = '0;
      if (pend_q && pend_en_q) addend_c = MIX_W'(sample_c);
   end

   // Snapshot, slot counter, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q    <= '0;
         en_snap   <= '0;
         inc_snap  <= '0;
         pend_q    <= 1'b0;
         pend_en_q <= 1'b0;
         acc_q     <= '0;
         rom_addr  <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         mix_valid <= drain_c;
         busy      <= (state_d == FETCH) || (state_d == DRAIN);
         pend_q    <= issue_c;
         pend_en_q <= en_snap[slot_q];
         if (sample_tick && (state_q != IDLE)) overrun <= 1'b1;
         if (start_c) begin
            en_snap  <= voice_en;
            inc_snap <= phase_inc;
            acc_q    <= '0;
            slot_q   <= '0;
            rom_addr <= bank_addr_c;
         end
         if (issue_c) begin
            acc_q  <= acc_q + addend_c;
            slot_q <= slot_q + 1'b1;
            if (slot_q != LAST_SLOT) rom_addr <= bank_addr_c;
         end
         if (drain_c) begin
            acc_q   <= acc_q + addend_c;
            mix_out <= acc_q + addend_c;
         end
      end
   end

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized and directed bench for voice_scheduler against a transaction-level model.
module tb_voice_scheduler;

   localparam int NV = 4;
   localparam int PB = 24;
   localparam int AB = 8;
   localparam int DB = 12;
   localparam int MW = 14;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  sample_tick = 1'b0;
   logic [NV-1:0]         voice_en = '0;
   logic [NV*PB-1:0]      phase_inc = '0;
   logic [AB-1:0]         rom_addr;
   logic [DB-1:0]         rom_data = '0;
   logic signed [MW-1:0]  mix_out;
   logic                  mix_valid, busy, overrun;

   always #5 clk = ~clk;

   voice_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (sample_tick),
      .voice_en    (voice_en),
      .phase_inc   (phase_inc),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .mix_out     (mix_out),
      .mix_valid   (mix_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   // Sine ROM stand-in: rom[a] = a*16, one-cycle registered read.
   always @(posedge clk) rom_data <= {rom_addr, 4'b0000};

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Transaction model: a whole sample is evaluated the moment a tick is accepted.
   bit            mdl_ok = 0;
   bit            active = 0;
   int            t0 = 0;
   logic [PB-1:0] mph [NV];
   logic [AB-1:0] maddr [NV];
   int            sum_pend = 0;
   int            mix_hold = 0;
   int            rom_hold = 0;
   bit            ovr = 0;

   always @(posedge clk) begin
      int c;
      c = cyc;
      cyc++;
      if (!rst_n) begin
         mdl_ok   = 1;
         active   = 0;
         ovr      = 0;
         mix_hold = 0;
         rom_hold = 0;
         for (int v = 0; v < NV; v++) mph[v] = '0;
      end else if (mdl_ok) begin
         if (sample_tick) begin
            if (!active || c > t0 + NV + 2) begin
               t0       = c;
               active   = 1;
               sum_pend = 0;
               for (int v = 0; v < NV; v++) begin
                  maddr[v] = mph[v][PB-1 -: AB];
                  if (voice_en[v]) begin
                     sum_pend += int'(maddr[v]) * 16 - 2048;
                     mph[v]   += phase_inc[v*PB +: PB];
                  end else begin
                     mph[v] = '0;
                  end
               end
            end else begin
               ovr = 1;
            end
         end
         if (active && (c + 1 >= t0 + 1) && (c + 1 <= t0 + NV)) rom_hold = int'(maddr[c - t0]);
         if (active && (c + 1 == t0 + NV + 2)) mix_hold = sum_pend;
      end
   end

   int q_mix [$];
   int q_vc  [$];

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (mdl_ok) begin
         bit eb, ev;
         eb = active && (cyc >= t0 + 1) && (cyc <= t0 + NV + 1);
         ev = active && (cyc == t0 + NV + 2);
         chk("busy", busy, eb);
         chk("mix_valid", mix_valid, ev);
         chk("mix_out", mix_out, mix_hold);
         chk("rom_addr", rom_addr, rom_hold);
         chk("overrun", overrun, ovr);
         if (mix_valid === 1'b1) begin
            q_mix.push_back(int'(mix_out));
            q_vc.push_back(cyc);
         end
      end
   end

   task automatic cwait(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      cwait(1);
      sample_tick = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      sample_tick = 1'b0;
      cwait(2);
      rst_n = 1'b1;
      cwait(1);
      q_mix.delete();
      q_vc.delete();
   endtask

   task automatic set_voice(int v, bit en, logic [PB-1:0] inc);
      voice_en[v]           = en;
      phase_inc[v*PB +: PB] = inc;
   endtask

   task automatic chk_mix_list(string nm, int exp [$]);
      chk({nm, "_count"}, q_mix.size(), exp.size());
      for (int i = 0; i < exp.size() && i < q_mix.size(); i++) chk(nm, q_mix[i], exp[i]);
   endtask

   initial begin
      int t;
      int exp_l [$];

      cwait(1);
      do_reset();
      chk("reset_mix_out", mix_out, 0);
      chk("reset_overrun", overrun, 0);

      // Voice 0 alone steps one ROM address per sample.
      voice_en = '0; phase_inc = '0;
      set_voice(0, 1, 24'h010000);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("v0_addr", rom_addr, i);
         cwait(9);
      end
      exp_l = '{-2048, -2032, -2016, -2000};
      chk_mix_list("v0_mix", exp_l);

      // All voices at address 0: full negative scale, exact latency.
      do_reset();
      voice_en = '1; phase_inc = '0;
      t = cyc;
      tick();
      chk("all_busy_t1", busy, 1);
      cwait(10);
      exp_l = '{-8192};
      chk_mix_list("all_mix", exp_l);
      if (q_vc.size() > 0) chk("all_latency", q_vc[0] - t, 6);

      // Voice 1 at half-cycle increment wraps every other sample.
      do_reset();
      voice_en = '0; phase_inc = '0;
      set_voice(1, 1, 24'h800000);
      for (int i = 0; i < 4; i++) begin
         tick();
         cwait(1);
         chk("v1_addr", rom_addr, (i % 2) * 128);
         cwait(8);
      end
      exp_l = '{-2048, 0, -2048, 0};
      chk_mix_list("v1_mix", exp_l);

      // Second tick while busy is dropped and latches overrun.
      do_reset();
      voice_en = '0; phase_inc = '0;
      set_voice(0, 1, 24'h010000);
      tick();
      cwait(2);
      tick();
      cwait(10);
      chk("ovr_valid_count", q_mix.size(), 1);
      chk("ovr_set", overrun, 1);
      tick();
      cwait(10);
      chk("ovr_sticky", overrun, 1);

      // Disabling a voice clears its phase.
      do_reset();
      voice_en = '0; phase_inc = '0;
      for (int i = 0; i < 5; i++) begin
         set_voice(0, (i != 3), 24'h010000);
         tick();
         chk("dis_addr", rom_addr, (i == 4) ? 0 : i);
         cwait(9);
      end
      exp_l = '{-2048, -2032, -2016, 0, -2048};
      chk_mix_list("dis_mix", exp_l);

      // Reset mid-computation aborts and clears phases.
      do_reset();
      voice_en = '1;
      for (int v = 0; v < NV; v++) set_voice(v, 1, 24'h230000 + PB'(v) * 24'h110000);
      tick();
      tick();
      cwait(8);
      q_mix.delete();
      tick();
      cwait(2);
      rst_n = 1'b0;
      cwait(1);
      rst_n = 1'b1;
      cwait(8);
      chk("abort_no_valid", q_mix.size(), 0);
      chk("abort_mix_out", mix_out, 0);
      chk("abort_overrun", overrun, 0);
      tick();
      for (int s = 0; s < NV; s++) begin
         chk("abort_fresh_addr", rom_addr, 0);
         cwait(1);
      end
      cwait(6);

      // Random traffic including ticks near busy/done boundaries and resets.
      do_reset();
      for (int it = 0; it < 400; it++) begin
         voice_en = NV'($urandom);
         for (int v = 0; v < NV; v++)
            phase_inc[v*PB +: PB] = ($urandom_range(0, 3) == 0) ? PB'($urandom_range(0, 4)) << 16 : PB'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            cwait(1);
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 3) != 0) tick();
         cwait($urandom_range(0, 9));
      end
      cwait(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
